// File: rtl/hex_display_pkg.sv
// Shared definitions for the memory-mapped 7-segment display controller:
// register offsets, CTRL bit positions, blank pattern and hex glyph table.
package hex_display_pkg;

  localparam logic [3:0] ADDR_CTRL         = 4'h0;
  localparam logic [3:0] ADDR_VALUE        = 4'h1;
  localparam logic [3:0] ADDR_BLINK_MASK   = 4'h2;
  localparam logic [3:0] ADDR_BLINK_PERIOD = 4'h3;
  localparam logic [3:0] ADDR_RAW0         = 4'h4;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_LZS    = 2;
  localparam int CTRL_PHASE  = 31;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit0=a .. bit6=g; element 15 is listed first.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_display_ctrl_hex7seg_decode.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex7seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS 7-segment digits with hex/raw modes,
// leading-zero suppression and per-digit blinking; hex_out is registered.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int          NUM_DIGITS = 6,
  parameter int unsigned BLINK_RST  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_DIGITS*7-1:0] hex_out
);

  localparam int VW = NUM_DIGITS * 4;
  localparam int HW = NUM_DIGITS * 7;

  logic [2:0]            ctrl;
  logic [VW-1:0]         value;
  logic [NUM_DIGITS-1:0] blink_mask;
  logic [31:0]           blink_period;
  logic [31:0]           blink_count;
  logic                  phase;
  logic [6:0]            raw [NUM_DIGITS];
  logic [6:0]            glyph [NUM_DIGITS];
  logic [HW-1:0]         next_hex;
  logic                  wr_en;
  logic                  period_wr;

  // A bus write is a single-cycle strobe: chipselect high with write_n low.
  assign wr_en     = chipselect && !write_n;
  assign period_wr = wr_en && (address == ADDR_BLINK_PERIOD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl         <= '0;
      value        <= '0;
      blink_mask   <= '0;
      blink_period <= 32'(BLINK_RST);
      for (int i = 0; i < NUM_DIGITS; i++) raw[i] <= SEG_BLANK;
    end else if (wr_en) begin
      case (address)
        ADDR_CTRL:         ctrl         <= writedata[2:0];
        ADDR_VALUE:        value        <= writedata[VW-1:0];
        ADDR_BLINK_MASK:   blink_mask   <= writedata[NUM_DIGITS-1:0];
        ADDR_BLINK_PERIOD: blink_period <= writedata;
        default: begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (address == ADDR_RAW0 + 4'(i)) raw[i] <= writedata[6:0];
        end
      endcase
    end
  end

  // A period rewrite restarts the blink cycle in the visible phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_count <= '0;
      phase       <= 1'b1;
    end else if (period_wr || blink_period == 32'd0) begin
      blink_count <= '0;
      phase       <= 1'b1;
    end else if (blink_count >= blink_period - 32'd1) begin
      blink_count <= '0;
      phase       <= ~phase;
    end else begin
      blink_count <= blink_count + 32'd1;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL: begin
        readdata[2:0]        = ctrl;
        readdata[CTRL_PHASE] = phase;
      end
      ADDR_VALUE:        readdata[VW-1:0]         = value;
      ADDR_BLINK_MASK:   readdata[NUM_DIGITS-1:0] = blink_mask;
      ADDR_BLINK_PERIOD: readdata                 = blink_period;
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (address == ADDR_RAW0 + 4'(i)) readdata[6:0] = raw[i];
      end
    endcase
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex7seg_decode u_decode (
      .nibble (value[4*g +: 4]),
      .glyph  (glyph[g])
    );
  end

  // Scan from the top digit down; upper_zero stays set while every nibble
  // seen so far is zero, which marks the leading zeros to suppress.
  logic       upper_zero;
  logic       suppress;
  logic [6:0] seg;

  always_comb begin
    next_hex   = '1;
    upper_zero = 1'b1;
    suppress   = 1'b0;
    seg        = SEG_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (value[4*i +: 4] == 4'h0);
      suppress   = ctrl[CTRL_LZS] && !ctrl[CTRL_MODE] && (i != 0) && upper_zero;
      seg        = ctrl[CTRL_MODE] ? raw[i] : glyph[i];
      if (ctrl[CTRL_ENABLE] && !(blink_mask[i] && !phase) && !suppress)
        next_hex[7*i +: 7] = seg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hex_out <= '1;
    else          hex_out <= next_hex;
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed and randomized bench for hex_display_ctrl against a behavioural
// model of the register file, blink timing and digit rendering.
module tb_hex_display_ctrl;

  localparam int ND  = 6;
  localparam int unsigned BRST = 25000000;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [41:0] hex_out;

  hex_display_ctrl #(.NUM_DIGITS(ND), .BLINK_RST(BRST)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .hex_out    (hex_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic [23:0] m_value;
  logic [5:0]  m_mask;
  logic [31:0] m_period;
  logic [6:0]  m_raw [ND];
  int          m_k;
  logic        m_phase;
  logic [41:0] exp_hex;

  function automatic logic [41:0] model_display();
    logic [41:0] d;
    int msd;
    logic blank;
    logic [6:0] s;
    msd = 0;
    for (int i = 0; i < ND; i++)
      if (m_value[4*i +: 4] != 4'h0) msd = i;
    for (int i = 0; i < ND; i++) begin
      s = m_ctrl[1] ? m_raw[i] : glyph_tab[m_value[4*i +: 4]];
      blank = !m_ctrl[0] || (m_mask[i] && !m_phase) ||
              (!m_ctrl[1] && m_ctrl[2] && i > msd);
      d[7*i +: 7] = blank ? 7'h7F : s;
    end
    return d;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a == 4'h0) r = {m_phase, 28'd0, m_ctrl};
    else if (a == 4'h1) r = {8'd0, m_value};
    else if (a == 4'h2) r = {26'd0, m_mask};
    else if (a == 4'h3) r = m_period;
    else if (a >= 4'h4 && a < 4'(4 + ND)) r = {25'd0, m_raw[a - 4'h4]};
    return r;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_value = '0; m_mask = '0; m_period = BRST;
    for (int i = 0; i < ND; i++) m_raw[i] = 7'h7F;
    m_k = 0; m_phase = 1'b1; exp_hex = ALL_BLANK;
  endtask

  // One clock edge: display reflects pre-edge state, then writes and timer advance.
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      exp_hex = model_display();
      if (chipselect && !write_n) begin
        if (address == 4'h0) m_ctrl = writedata[2:0];
        else if (address == 4'h1) m_value = writedata[23:0];
        else if (address == 4'h2) m_mask = writedata[5:0];
        else if (address >= 4'h4 && address < 4'(4 + ND)) m_raw[address - 4'h4] = writedata[6:0];
      end
      if (chipselect && !write_n && address == 4'h3) begin
        m_period = writedata;
        m_k = 0;
      end else begin
        m_k++;
      end
      m_phase = (m_period == 0) ? 1'b1 : (((m_k / int'(m_period)) % 2) == 0);
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_model(input logic [3:0] a, input string tag);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(tag, 64'(readdata), 64'(model_read(a)));
    chipselect = 1'b0;
  endtask

  task automatic read_const(input logic [3:0] a, input logic [31:0] e, input string tag);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(tag, 64'(readdata), 64'(e));
    chipselect = 1'b0;
  endtask

  task automatic check_hex(input string tag);
    check(tag, 64'(hex_out), 64'(exp_hex));
  endtask

  initial begin
    logic [3:0] a;
    logic [31:0] d;

    // Reset
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    model_reset();
    repeat (3) tick();
    check("reset_hex", 64'(hex_out), 64'(ALL_BLANK));
    read_const(4'h0, 32'h8000_0000, "reset_ctrl");
    read_const(4'h3, BRST, "reset_period");
    read_const(4'h4, 32'h7F, "reset_raw0");
    reset_n = 1'b1;
    tick();

    // Hex decode
    do_write(4'h1, 32'h00A81F);
    do_write(4'h0, 32'h1);
    tick();
    check("hex_decode", 64'(hex_out), 64'({7'h40, 7'h40, 7'h08, 7'h00, 7'h79, 7'h0E}));
    check_hex("hex_decode_model");

    // Leading-zero suppression
    do_write(4'h1, 32'h000010);
    do_write(4'h0, 32'h5);
    tick();
    check("lzs_10", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40}));
    do_write(4'h1, 32'h0);
    tick();
    check("lzs_zero", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // Raw mode, LZS ignored
    do_write(4'h6, 32'h12);
    do_write(4'h0, 32'h3);
    tick();
    check("raw_digit2", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h7F, 7'h7F}));
    read_const(4'h6, 32'h12, "raw2_read");

    // Blink
    do_write(4'h3, 32'd4);
    do_write(4'h2, 32'h01);
    do_write(4'h0, 32'h1);
    do_write(4'h1, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_hex("blink_hex");
      check("blink_digit1", 64'(hex_out[13:7]), 64'(7'h40));
    end
    for (int i = 0; i < 10 && m_phase; i++) begin
      tick();
      check_hex("blink_seek_hex");
    end
    read_const(4'h0, 32'h0000_0001, "off_phase");
    do_write(4'h3, 32'd4);
    read_const(4'h0, 32'h8000_0001, "rewrite_phase");
    tick();
    check("rewrite_digit0", 64'(hex_out[6:0]), 64'(7'h40));

    // Period 0 holds phase visible
    do_write(4'h3, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      read_const(4'h0, 32'h8000_0001, "period0_phase");
    end

    // Period 1 toggles every cycle
    do_write(4'h3, 32'd1);
    for (int i = 0; i < 8; i++) begin
      read_const(4'h0, {(i % 2 == 0), 28'd0, 3'b001}, "period1_phase");
      tick();
      check_hex("period1_hex");
    end

    read_const(4'hF, 32'h0, "unmapped_read");
    do_write(4'hF, 32'hFFFF_FFFF);
    read_model(4'h1, "unmapped_write_value");

    // Reset mid-blink with a write in flight
    do_write(4'h3, 32'd3);
    do_write(4'h2, 32'h3F);
    repeat (5) tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_hex", 64'(hex_out), 64'(ALL_BLANK));
    address = 4'h1; writedata = 32'h123456; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b1;
    read_const(4'h1, 32'h0, "reset_discard_write");
    read_const(4'h0, 32'h8000_0000, "reset_ctrl2");
    do_write(4'h3, 32'd2);
    do_write(4'h2, 32'h3F);
    do_write(4'h0, 32'h1);
    repeat (6) begin
      tick();
      check_hex("restart_hex");
    end

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        a = 4'($urandom_range(0, 15));
        d = $urandom;
        if (a == 4'h3) d = $urandom_range(0, 6);
        do_write(a, d);
      end else begin
        tick();
      end
      check_hex("rand_hex");
      read_model(4'($urandom_range(0, 15)), "rand_read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
